// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_defs: shared definitions for the bit-serial adder controller.
//   - state_t : FSM state encodings (IDLE, RUN, FIN)
//   - DEF_WIDTH / DEF_CNT_W : default operand width and bit-counter width
package serial_add_defs;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder shared by the serial datapath.
//   X, Y : operand bits
//   Z    : carry in
//   S    : sum bit
//   C    : carry out
module full_adder (
   input  logic X,
   input  logic Y,
   input  logic Z,
   output logic S,
   output logic C
);

   assign S = X ^ Y ^ Z;
   assign C = (X & Y) | (Z & (X ^ Y));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. One full_adder is reused
// over WIDTH cycles; the FSM sequences operand shifting, the carry FF, the
// bit counter and a START/BUSY/DONE handshake.
//
// Optional feature macro: SERIAL_ADD_SUB_EN (adds SUB input for A-B).
//
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   START : request, accepted in IDLE or FIN
//   A, B  : operands, captured on accept
//   CIN   : carry-in, captured on accept
//   SUB   : (SERIAL_ADD_SUB_EN only) subtract select, captured on accept
//   BUSY  : high while in RUN
//   DONE  : one-cycle pulse in FIN, result valid
//   SUM   : result, held until next accept
//   COUT  : carry out of MSB (no-borrow when subtracting)
//   OVF   : two's-complement overflow
module serial_add_ctrl
   import serial_add_defs::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             SUB,
`endif
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT,
   output logic             OVF
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q, sum_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q, cout_q, ovf_q;
   logic               accept, last, sub_sel;
   logic               fa_s, fa_c;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_sel = SUB;
`else
   assign sub_sel = 1'b0;
`endif

   assign last = (cnt_q == CNT_W'(WIDTH - 1));

   full_adder u_fa (
      .X (a_q[0]),
      .Y (b_q[0]),
      .Z (carry_q),
      .S (fa_s),
      .C (fa_c)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            BUSY = 1'b1;
            if (last) state_d = FIN;
         end
         FIN: begin
            DONE    = 1'b1;
            state_d = IDLE;
            // back-to-back accept: same load action as from IDLE
            if (START) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= A;
            // subtraction is A + ~B + 1; CIN is ignored in that mode
            b_q     <= sub_sel ? ~B : B;
            carry_q <= sub_sel ? 1'b1 : CIN;
            cnt_q   <= '0;
            sum_q   <= '0;
         end else if (state_q == RUN) begin
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            carry_q <= fa_c;
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last) begin
               // carry_q here is the carry into the MSB
               ovf_q  <= carry_q ^ fa_c;
               cout_q <= fa_c;
            end
         end
      end
   end

   assign SUM  = sum_q;
   assign COUT = cout_q;
   assign OVF  = ovf_q;

endmodule
